serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial N-bit adder controller that time-shares a single one-bit full-adder cell, built from two `half_adder` instances plus an OR of their carries, across all bit positions of two operands. It accepts an operand pair on a start pulse and sequences one bit per clock, LSB first, through the shared cell. It returns the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting FSM or test driver and the existing `half_adder` datapath.

## Interface

Parameters:
- `WIDTH`, default 8, operand/sum width in bits; legal range 2..32.

Ports:
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `sys_rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `op_a`  in  WIDTH  operand A; captured on the accepted start edge.
- `op_b`  in  WIDTH  operand B; captured on the accepted start edge.
- `busy`  out  1  high in RUN and DONE states.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result, op_a + op_b mod 2^WIDTH.
- `cout`  out  1  registered carry-out of bit WIDTH-1.

## Operation

- FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - If `start` = 1: load `op_a` and `op_b` into shift registers `sa` and `sb`.
  - Clear the carry flop and the bit counter `cnt` (width clog2(WIDTH)).
  - Go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each cycle:
  - Shared cell inputs are `sa[0]`, `sb[0]` and the carry flop.
  - Shift the cell's sum bit into the MSB of result shift register `sr`.
  - Shift `sa` and `sb` right by one.
  - Update the carry flop with the cell's carry.
  - Increment `cnt`.
  - When `cnt` = WIDTH-1 (last bit):
    - Load `sum` from the final `sr` contents, including this cycle's bit.
    - Load `cout` from the cell carry of this cycle.
    - Go to DONE.
- **DONE**
  - `done` = 1 for exactly this cycle.
  - Go to IDLE unconditionally.
- `start` is ignored in RUN and DONE; it is not queued.
- `op_a` and `op_b` changes after capture have no effect on the operation in flight.
- Exactly one shared adder cell is used; no parallel WIDTH-bit adder is permitted.
- `sum` and `cout` change only on the transition into DONE. They hold their value through subsequent IDLE and RUN periods until the next completion.
- Arithmetic is unsigned.
  - `{cout, sum}` = `op_a` + `op_b` as a WIDTH+1-bit value.
  - Overflow beyond WIDTH bits appears only on `cout`.

## Timing

- **Reset (asynchronous, any time):**
  - State goes to IDLE.
  - `busy` = 0, `done` = 0, `sum` = 0, `cout` = 0.
  - Shift registers, counter and carry flop are cleared.
  - An operation in flight is abandoned with no `done`.
  - The first `start` after reset deassertion is accepted normally.
- Let E0 be the edge that samples `start` = 1 in IDLE.
  - `busy` rises after E0.
  - Edges E1..E(WIDTH) process bits 0..WIDTH-1.
  - After E(WIDTH): state = DONE, `done` = 1, and `sum`/`cout` are valid.
  - After E(WIDTH+1): `done` = 0, `busy` = 0, state = IDLE.
- Latency from accepted start to `done` is WIDTH cycles. Busy period is WIDTH+1 cycles.
- Minimum start-to-start throughput is WIDTH+2 cycles.
  - The earliest re-accept edge is the one after `done` deasserts, i.e. E(WIDTH+2).
  - `start` held continuously high therefore restarts every WIDTH+2 cycles, using operands sampled at each accept edge.
- The carry flop is cleared at every accept, so no carry leaks between operations.

## Test plan

- WIDTH=8, reset, then start with 0x00+0x00 -> `done` exactly 8 cycles after accept; `sum`=0x00, `cout`=0. Check all outputs are 0 during and after reset.
- 0xFF+0x01 -> `sum`=0x00, `cout`=1 (full carry ripple). Then 0xA5+0x5A -> `sum`=0xFF, `cout`=0, with the previous result held until the new `done`.
- 0xFF+0xFF -> `sum`=0xFE, `cout`=1. Pulse `start` and change `op_a`/`op_b` to 0x00 during RUN -> no effect and a single `done`.
- Assert `sys_rst` asynchronously mid-cycle after bit 4 of 0x0F+0x01 -> `busy`/`sum`/`cout` go to 0 immediately, no `done`. Then after release, 0x03+0x04 -> `sum`=0x07.
- `start` held high with operands changing each cycle -> accepts spaced exactly 10 cycles apart, each result matching the operands sampled at its accept edge.
- 500 random operand pairs (`$random`-driven, start at random gaps) -> `{cout,sum}` == `op_a`+`op_b` at every `done`, and `done` is never wider than 1 cycle.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit unsigned adder: one shared full-adder cell (two half
// adders plus an OR) processes the operands LSB first, one bit per clock.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic ha0_s, ha0_c, ha1_s, ha1_c, cell_c;

    // The single shared full-adder cell.
    half_adder u_ha0 (.a(sa[0]), .b(sb[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.a(ha0_s), .b(carry), .s(ha1_s), .c(ha1_c));
    assign cell_c = ha0_c | ha1_c;
    assign sr_nxt = {ha1_s, sr[WIDTH-1:1]};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa    <= op_a;
                    sb    <= op_b;
                    sr    <= '0;
                    cnt   <= '0;
                    carry <= 1'b0;
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= sr_nxt;
                    carry <= cell_c;
                    cnt   <= cnt + CNT_W'(1);
                    // Last bit: publish result including this cycle's sum bit.
                    if (cnt == LAST) begin
                        sum  <= sr_nxt;
                        cout <= cell_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner
// sequences and random traffic, results checked through an expected-result queue.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         sys_clk = 1'b0;
    logic         sys_rst = 1'b1;
    logic         start   = 1'b0;
    logic [W-1:0] op_a    = '0;
    logic [W-1:0] op_b    = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .sum(sum), .cout(cout)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev_done = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge sys_clk) begin
        if (done === 1'b1) begin
            check("done_width", {63'b0, prev_done}, 64'd0);
            if (q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", {56'b0, sum}, {56'b0, e.s});
                check("cout", {63'b0, cout}, {63'b0, e.c});
                check("latency", 64'(cyc - e.acc), 64'(W));
            end
        end
        prev_done = (done === 1'b1);
    end

    // Drive one start pulse from IDLE; optionally record the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] es, input logic ec);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge sys_clk);
        while (busy !== 1'b0 && guard < 50) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 50) check("idle_timeout", 64'd1, 64'd0);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge sys_clk);
        #1;
        start = 1'b0;
        e.s = es; e.c = ec; e.acc = cyc;
        if (push) q.push_back(e);
        check("busy_after_accept", {63'b0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((q.size() != 0 || busy !== 1'b0) && guard < 60) begin
            @(negedge sys_clk);
            guard++;
        end
        if (guard >= 60) check("drain_timeout", 64'd1, 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[4] = '{8'h03, 8'h04, 8'h07, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[7] = '{8'h3C, 8'hC3, 8'hFF, 1'b0};

        // Reset behaviour
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_sum",  {56'b0, sum},  64'd0);
        check("rst_cout", {63'b0, cout}, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("post_rst_busy", {63'b0, busy}, 64'd0);
        check("post_rst_sum",  {56'b0, sum},  64'd0);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, 1'b1, vecs[i].s, vecs[i].c);
            wait_idle();
        end

        // Previous result held until the next completion
        issue(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1);
        wait_idle();
        issue(8'hA5, 8'h5A, 1'b1, 8'hFF, 1'b0);
        repeat (3) @(negedge sys_clk);
        check("held_sum",  {56'b0, sum},  64'h00);
        check("held_cout", {63'b0, cout}, 64'd1);
        wait_idle();

        // Start pulse and operand change during RUN are ignored
        issue(8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1);
        @(negedge sys_clk);
        start = 1'b1; op_a = 8'h00; op_b = 8'h00;
        @(negedge sys_clk);
        start = 1'b0;
        wait_idle();
        repeat (12) @(negedge sys_clk);
        check("ignored_sum", {56'b0, sum}, 64'hFE);

        // Asynchronous reset mid-operation after bit 4
        issue(8'h0F, 8'h01, 1'b0, 8'h00, 1'b0);
        repeat (4) @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_sum",  {56'b0, sum},  64'd0);
        check("midrst_cout", {63'b0, cout}, 64'd0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (12) @(negedge sys_clk);
        check("midrst_no_done_sum", {56'b0, sum}, 64'd0);
        issue(8'h03, 8'h04, 1'b1, 8'h07, 1'b0);
        wait_idle();

        // start held high: accepts every W+2 cycles with fresh operands
        for (int k = 0; k < 3 * (W + 2); k++) begin
            logic [W-1:0] a, b;
            @(negedge sys_clk);
            a = W'($urandom);
            b = W'($urandom);
            start = 1'b1; op_a = a; op_b = b;
            @(posedge sys_clk);
            #1;
            if (k % (W + 2) == 0) begin
                exp_t e;
                logic [W:0] t;
                t = {1'b0, a} + {1'b0, b};
                e.s = t[W-1:0]; e.c = t[W]; e.acc = cyc;
                q.push_back(e);
            end
        end
        @(negedge sys_clk);
        start = 1'b0;
        wait_idle();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            logic [W-1:0] a, b;
            logic [W:0]   t;
            a = W'($urandom);
            b = W'($urandom);
            t = {1'b0, a} + {1'b0, b};
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
            issue(a, b, 1'b1, t[W-1:0], t[W]);
        end
        wait_idle();
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
